// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe Q-learning definitions: Q-value type, action indexing and
// the max-Q search FSM encoding.
package tictactoe_pkg;

    localparam int Q_W   = 16;
    localparam int N_ACT = 9;
    localparam int IDX_W = 4;

    typedef logic signed [Q_W-1:0] q_t;
    typedef logic [IDX_W-1:0]      act_idx_t;

    localparam act_idx_t ACT_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } search_state_e;

    // Slot tag travelling alongside a Q-table read until its data returns.
    typedef struct packed {
        logic     legal;
        act_idx_t idx;
    } slot_tag_t;

endpackage

// File: rtl/max_q_search_if.sv
// Request/result and Q-table read signals of the max-Q search stage.
// master = requester plus Q-table, slave = the search block.
interface max_q_search_if #(
    parameter int AW = 14
);
    import tictactoe_pkg::*;

    logic             start;
    logic [AW-1:0]    state_base;
    logic [N_ACT-1:0] legal_mask;

    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    q_t               rd_data;

    logic             busy;
    logic             done;
    q_t               max_Q;
    act_idx_t         best_action;
    logic             no_legal;

    modport master (
        output start, state_base, legal_mask, rd_data,
        input  rd_en, rd_addr, busy, done, max_Q, best_action, no_legal
    );

    modport slave (
        input  start, state_base, legal_mask, rd_data,
        output rd_en, rd_addr, busy, done, max_Q, best_action, no_legal
    );

endinterface

// File: rtl/q_max_cmp.sv
// Running-maximum decision: take the candidate when its slot is legal and it
// strictly beats the accumulator (signed), so ties keep the earlier index.
module q_max_cmp
    import tictactoe_pkg::*;
(
    input  q_t   cand_i,
    input  logic tag_legal_i,
    input  q_t   acc_i,
    input  logic acc_valid_i,
    output logic take_o
);

    assign take_o = tag_legal_i && (!acc_valid_i || (cand_i > acc_i));

endmodule

// File: rtl/max_q_search.sv
// Scans the N_ACT Q-table entries of one state through a 1-cycle-latency read
// port and reports the largest legal Q value and its action index.
module max_q_search
    import tictactoe_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    max_q_search_if.slave bus
);

    search_state_e    state_q, state_d;
    act_idx_t         idx_q, idx_d;
    logic [AW-1:0]    base_q, base_d;
    logic [N_ACT-1:0] mask_q, mask_d;
    slot_tag_t        tag_q, tag_d;
    q_t               acc_q, acc_d;
    logic             acc_valid_q, acc_valid_d;
    act_idx_t         acc_idx_q, acc_idx_d;
    q_t               res_max_q, res_max_d;
    act_idx_t         res_best_q, res_best_d;
    logic             res_none_q, res_none_d;
    logic             take;

    q_max_cmp u_cmp (
        .cand_i      (bus.rd_data),
        .tag_legal_i (tag_q.legal),
        .acc_i       (acc_q),
        .acc_valid_i (acc_valid_q),
        .take_o      (take)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_ISSUE;
            ST_ISSUE: if (idx_q == act_idx_t'(N_ACT - 1)) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state_q != ST_IDLE);
        bus.done    = (state_q == ST_DONE);
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        if (state_q == ST_ISSUE) begin
            bus.rd_en   = mask_q[idx_q];
            bus.rd_addr = base_q + AW'(idx_q);
        end
    end

    always_comb begin
        idx_d       = idx_q;
        base_d      = base_q;
        mask_d      = mask_q;
        tag_d       = '{legal: 1'b0, idx: '0};
        acc_d       = acc_q;
        acc_valid_d = acc_valid_q;
        acc_idx_d   = acc_idx_q;
        res_max_d   = res_max_q;
        res_best_d  = res_best_q;
        res_none_d  = res_none_q;

        if (state_q == ST_IDLE && bus.start) begin
            base_d      = bus.state_base;
            mask_d      = bus.legal_mask;
            idx_d       = '0;
            acc_d       = '0;
            acc_valid_d = 1'b0;
            acc_idx_d   = ACT_NONE;
        end

        if (state_q == ST_ISSUE) begin
            tag_d = '{legal: mask_q[idx_q], idx: idx_q};
            idx_d = idx_q + 4'd1;
        end

        if (take) begin
            acc_d       = bus.rd_data;
            acc_idx_d   = tag_q.idx;
            acc_valid_d = 1'b1;
        end

        // The last read lands in DRAIN, so the result registers load from the
        // next-state accumulator and are visible exactly in the DONE cycle.
        if (state_q == ST_DRAIN) begin
            res_max_d  = acc_valid_d ? acc_d : '0;
            res_best_d = acc_valid_d ? acc_idx_d : ACT_NONE;
            res_none_d = (mask_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            base_q      <= '0;
            mask_q      <= '0;
            tag_q       <= '{legal: 1'b0, idx: '0};
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
            acc_idx_q   <= ACT_NONE;
            res_max_q   <= '0;
            res_best_q  <= ACT_NONE;
            res_none_q  <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            base_q      <= base_d;
            mask_q      <= mask_d;
            tag_q       <= tag_d;
            acc_q       <= acc_d;
            acc_valid_q <= acc_valid_d;
            acc_idx_q   <= acc_idx_d;
            res_max_q   <= res_max_d;
            res_best_q  <= res_best_d;
            res_none_q  <= res_none_d;
        end
    end

    assign bus.max_Q       = res_max_q;
    assign bus.best_action = res_best_q;
    assign bus.no_legal    = res_none_q;

endmodule

// File: tb/tb_max_q_search.sv
// Directed bench for max_q_search: Q-table model, per-cycle read/busy checks
// and a result scoreboard consumed by a monitor on the falling edge.
module tb_max_q_search;
    import tictactoe_pkg::*;

    localparam int AW = 14;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    bit   mon_en;

    max_q_search_if #(.AW(AW)) bus ();

    max_q_search #(.AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        q_t       max_q;
        act_idx_t best;
        logic     none;
        int       cyc;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] exp_rd[int];
    bit            exp_busy[int];
    q_t            qmem[0:(1<<AW)-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Q-table with one cycle of read latency; data outside a read is undefined.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= qmem[bus.rd_addr];
        else           bus.rd_data <= 'x;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("rd_en", 32'(bus.rd_en), 32'(exp_rd.exists(cyc)));
            if (exp_rd.exists(cyc)) begin
                if (bus.rd_en) check("rd_addr", 32'(bus.rd_addr), 32'(exp_rd[cyc]));
                exp_rd.delete(cyc);
            end
            check("busy", 32'(bus.busy), 32'(exp_busy.exists(cyc)));
            if (exp_busy.exists(cyc)) exp_busy.delete(cyc);

            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'(bus.done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle",  32'(cyc),             32'(e.cyc));
                    check("max_Q",       32'(bus.max_Q),       32'(e.max_q));
                    check("best_action", 32'(bus.best_action), 32'(e.best));
                    check("no_legal",    32'(bus.no_legal),    32'(e.none));
                end
            end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
                check("done_missing", 32'(bus.done), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic load_q(input logic [AW-1:0] base, input q_t vals[N_ACT]);
        for (int a = 0; a < N_ACT; a++) qmem[base + AW'(a)] = vals[a];
    endtask

    // Drives start in the current cycle (sampled at the next edge = edge 0) and
    // returns in cycle 1. Slot a is read in cycle a+1; done lands in cycle 11.
    task automatic run_scan(input logic [AW-1:0] base, input logic [N_ACT-1:0] mask,
                            input q_t e_max, input act_idx_t e_best, input logic e_none,
                            input int n_cycles);
        int   k;
        exp_t e;
        bus.start      = 1'b1;
        bus.state_base = base;
        bus.legal_mask = mask;
        @(posedge clk);
        #1;
        k = cyc;
        bus.start      = 1'b0;
        bus.state_base = ~base;
        bus.legal_mask = ~mask;
        for (int a = 0; a < N_ACT; a++)
            if (mask[a] && a + 1 <= n_cycles) exp_rd[k + a] = base + AW'(a);
        for (int n = 1; n <= N_ACT + 2 && n <= n_cycles; n++) exp_busy[k + n - 1] = 1'b1;
        if (n_cycles >= N_ACT + 2) begin
            e = '{max_q: e_max, best: e_best, none: e_none, cyc: k + N_ACT + 1};
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("scan_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        q_t vals[N_ACT];
        checks         = 0;
        errors         = 0;
        cyc            = 0;
        mon_en         = 1'b0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.state_base = '0;
        bus.legal_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_busy",        32'(bus.busy),        32'd0);
        check("rst_done",        32'(bus.done),        32'd0);
        check("rst_rd_en",       32'(bus.rd_en),       32'd0);
        check("rst_rd_addr",     32'(bus.rd_addr),     32'd0);
        check("rst_max_Q",       32'(bus.max_Q),       32'd0);
        check("rst_best_action", 32'(bus.best_action), 32'hF);
        check("rst_no_legal",    32'(bus.no_legal),    32'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // 1: full mask, tie at 12 keeps action 2
        vals = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd12, 16'sd0, -16'sd1, 16'sd2, 16'sd9};
        load_q(14'h090, vals);
        run_scan(14'h090, 9'h1FF, 16'sd12, 4'd2, 1'b0, 99);
        wait_idle();

        // 2: no legal action; previous result holds during the scan
        run_scan(14'h150, 9'h000, 16'sd0, ACT_NONE, 1'b1, 99);
        repeat (3) @(posedge clk);
        #1;
        check("hold_max_Q",       32'(bus.max_Q),       32'(16'sd12));
        check("hold_best_action", 32'(bus.best_action), 32'd2);
        wait_idle();

        // 3: only actions 6 and 8 legal, both negative
        vals = '{16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000,
                 -16'sd200, 16'sd1000, -16'sd5};
        load_q(14'h200, vals);
        run_scan(14'h200, 9'h140, -16'sd5, 4'd8, 1'b0, 99);
        wait_idle();

        // 4: starts in cycles 3, 8 and the DONE cycle are ignored; restart at 12
        vals = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9};
        load_q(14'h300, vals);
        run_scan(14'h300, 9'h1FF, 16'sd9, 4'd8, 1'b0, 99);
        repeat (2) @(posedge clk);
        #1; bus.start = 1'b1;
        @(posedge clk);
        #1; bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1; bus.start = 1'b1;
        @(posedge clk);
        #1; bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1; bus.start = 1'b1;
        @(posedge clk);
        #1; bus.start = 1'b0;
        vals = '{-16'sd1, -16'sd1, -16'sd7, -16'sd1, 16'sd50, 16'sd50, 16'sd50, 16'sd50, 16'sd50};
        load_q(14'h310, vals);
        run_scan(14'h310, 9'h00F, -16'sd1, 4'd0, 1'b0, 99);
        wait_idle();

        // 5: reset in cycle 5 aborts the scan; outputs return to reset values
        run_scan(14'h090, 9'h1FF, 16'sd0, ACT_NONE, 1'b0, 5);
        repeat (4) @(posedge clk);
        #1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        check("abort_busy",        32'(bus.busy),        32'd0);
        check("abort_rd_en",       32'(bus.rd_en),       32'd0);
        check("abort_max_Q",       32'(bus.max_Q),       32'd0);
        check("abort_best_action", 32'(bus.best_action), 32'hF);
        check("abort_no_legal",    32'(bus.no_legal),    32'd0);
        repeat (2) @(posedge clk);
        #1;
        run_scan(14'h090, 9'h0A0, 16'sd2, 4'd7, 1'b0, 99);
        wait_idle();

        // 6: address wrap and signed compare 0x7FFF vs 0x8000
        vals = '{16'sh8000, 16'sh7FFF, 16'sd100, -16'sd4, 16'sh7FFE,
                 16'sd0, 16'sh8001, 16'sd3, 16'sh7FFF};
        load_q(14'h3FFC, vals);
        run_scan(14'h3FFC, 9'h1FF, 16'sh7FFF, 4'd1, 1'b0, 99);
        wait_idle();

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty",     32'(sb.size()),       32'd0);
        check("reads_left",   32'(exp_rd.num()),    32'd0);
        check("busy_left",    32'(exp_busy.num()),  32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
